// File: rtl/pll_reconfig_sequencer.sv
// Purpose: read-modify-write one MMCM/PLL DRP register with the PLL held in reset, then wait for LOCKED.
// Latency: accept -> done = 5 + DRP read/write latency + RST_HOLD + lock time (>= LOCK_BLANK+1) cycles.
// Backpressure: cfg_ready high only when idle (one request in flight); drp_rdy/lock waits bounded by LOCK_TIMEOUT.
//
// Ports:
//   clk_125mhz, rst_n            : clock, synchronous active-low reset
//   cfg_valid/cfg_ready          : request handshake; cfg_addr/cfg_data/cfg_mask captured on accept
//                                  (mask bit 1 keeps the current register bit, 0 takes cfg_data)
//   drp_en/we/addr/di, drp_do/rdy: DRP master towards the MMCM/PLL
//   mmcm_rst, mmcm_locked        : PLL reset (held across the DRP access) and its LOCKED output
//   busy, done, err              : sequencer active; one-cycle success pulse; one-cycle timeout pulse
module pll_reconfig_sequencer #(
  parameter int RST_HOLD     = 8,
  parameter int LOCK_TIMEOUT = 50000,
  parameter int LOCK_BLANK   = 4
) (
  input  logic        clk_125mhz,
  input  logic        rst_n,
  input  logic        cfg_valid,
  output logic        cfg_ready,
  input  logic [6:0]  cfg_addr,
  input  logic [15:0] cfg_data,
  input  logic [15:0] cfg_mask,
  output logic        drp_en,
  output logic        drp_we,
  output logic [6:0]  drp_addr,
  output logic [15:0] drp_di,
  input  logic [15:0] drp_do,
  input  logic        drp_rdy,
  output logic        mmcm_rst,
  input  logic        mmcm_locked,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam int CNT_MAX = (LOCK_TIMEOUT > RST_HOLD) ? LOCK_TIMEOUT : RST_HOLD;
  localparam int CW      = $clog2(CNT_MAX + 1);

  // Counter compare points: the counter reads k-1 on the k-th edge spent in a state.
  localparam logic [CW-1:0] TO_LAST   = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(RST_HOLD - 1);
  localparam logic [CW-1:0] BLANK     = CW'(LOCK_BLANK);

  typedef enum logic [2:0] {
    IDLE,
    ASSERT_RST,
    READ,
    WAIT_READ,
    WRITE,
    WAIT_WRITE,
    HOLD_RST,
    WAIT_LOCK
  } state_t;

  state_t      state;
  logic [CW-1:0] cnt;
  logic [6:0]  addr_q;
  logic [15:0] data_q;
  logic [15:0] mask_q;
  logic [15:0] new_q;

  always_ff @(posedge clk_125mhz) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      mask_q    <= '0;
      new_q     <= '0;
      cfg_ready <= 1'b0;
      busy      <= 1'b0;
      mmcm_rst  <= 1'b0;
      drp_en    <= 1'b0;
      drp_we    <= 1'b0;
      drp_addr  <= '0;
      drp_di    <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      // Strobes and status pulses default low so each is exactly one cycle wide.
      drp_en <= 1'b0;
      drp_we <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;

      case (state)
        IDLE: begin
          cnt       <= '0;
          busy      <= 1'b0;
          cfg_ready <= 1'b1;
          if (cfg_valid && cfg_ready) begin
            addr_q    <= cfg_addr;
            data_q    <= cfg_data;
            mask_q    <= cfg_mask;
            cfg_ready <= 1'b0;
            busy      <= 1'b1;
            mmcm_rst  <= 1'b1;
            state     <= ASSERT_RST;
          end
        end

        ASSERT_RST: begin
          // Issue the read strobe so it is on the bus while the FSM sits in READ.
          drp_en   <= 1'b1;
          drp_addr <= addr_q;
          state    <= READ;
        end

        READ: begin
          cnt   <= '0;
          state <= WAIT_READ;
        end

        WAIT_READ: begin
          if (drp_rdy) begin
            new_q <= (drp_do & mask_q) | (data_q & ~mask_q);
            state <= WRITE;
          end else if (cnt == TO_LAST) begin
            err       <= 1'b1;
            mmcm_rst  <= 1'b0;
            busy      <= 1'b0;
            cfg_ready <= 1'b1;
            state     <= IDLE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        WRITE: begin
          // Merged word was registered in WAIT_READ; strobe it out from here,
          // which puts the write strobe two cycles after the read drp_rdy.
          drp_en <= 1'b1;
          drp_we <= 1'b1;
          drp_di <= new_q;
          cnt    <= '0;
          state  <= WAIT_WRITE;
        end

        WAIT_WRITE: begin
          if (drp_rdy) begin
            cnt   <= '0;
            state <= HOLD_RST;
          end else if (cnt == TO_LAST) begin
            err       <= 1'b1;
            mmcm_rst  <= 1'b0;
            busy      <= 1'b0;
            cfg_ready <= 1'b1;
            state     <= IDLE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        HOLD_RST: begin
          if (cnt == HOLD_LAST) begin
            mmcm_rst <= 1'b0;
            cnt      <= '0;
            state    <= WAIT_LOCK;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        WAIT_LOCK: begin
          // LOCKED may still be high from before the reset; trust it only after the blank window.
          if (cnt >= BLANK && mmcm_locked) begin
            done      <= 1'b1;
            busy      <= 1'b0;
            cfg_ready <= 1'b1;
            state     <= IDLE;
          end else if (cnt == TO_LAST) begin
            err       <= 1'b1;
            busy      <= 1'b0;
            cfg_ready <= 1'b1;
            state     <= IDLE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        default: begin
          mmcm_rst <= 1'b0;
          busy     <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pll_reconfig_sequencer.sv
// Purpose: randomized and directed checks of pll_reconfig_sequencer against a transaction timeline model.
// Latency: model predicts the edge of every strobe, reset edge and done/err pulse from the request parameters.
// Backpressure: cfg_valid may be held high across a whole sequence; acceptance is predicted from cfg_ready.
module tb_pll_reconfig_sequencer;

  localparam int RST_HOLD     = 8;
  localparam int LOCK_TIMEOUT = 60;
  localparam int LOCK_BLANK   = 4;

  logic        clk_125mhz = 1'b0;
  logic        rst_n;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [6:0]  cfg_addr;
  logic [15:0] cfg_data;
  logic [15:0] cfg_mask;
  logic        drp_en;
  logic        drp_we;
  logic [6:0]  drp_addr;
  logic [15:0] drp_di;
  logic [15:0] drp_do;
  logic        drp_rdy;
  logic        mmcm_rst;
  logic        mmcm_locked;
  logic        busy;
  logic        done;
  logic        err;

  always #4 clk_125mhz = ~clk_125mhz;

  pll_reconfig_sequencer #(
    .RST_HOLD    (RST_HOLD),
    .LOCK_TIMEOUT(LOCK_TIMEOUT),
    .LOCK_BLANK  (LOCK_BLANK)
  ) dut (
    .clk_125mhz (clk_125mhz),
    .rst_n      (rst_n),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_addr   (cfg_addr),
    .cfg_data   (cfg_data),
    .cfg_mask   (cfg_mask),
    .drp_en     (drp_en),
    .drp_we     (drp_we),
    .drp_addr   (drp_addr),
    .drp_di     (drp_di),
    .drp_do     (drp_do),
    .drp_rdy    (drp_rdy),
    .mmcm_rst   (mmcm_rst),
    .mmcm_locked(mmcm_locked),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;         // index of the most recent rising edge
  int ready_from = 0;  // model: cfg_ready is high after this edge (while idle)

  task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at edge %0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk_125mhz);
    cyc++;
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk_val({tag, "_busy"}, busy, 0);
    chk_val({tag, "_mmcm_rst"}, mmcm_rst, 0);
    chk_val({tag, "_drp_en"}, drp_en, 0);
    chk_val({tag, "_drp_we"}, drp_we, 0);
    chk_val({tag, "_done"}, done, 0);
    chk_val({tag, "_err"}, err, 0);
    chk_val({tag, "_cfg_ready"}, cfg_ready, 0);
    chk_val({tag, "_drp_addr"}, drp_addr, 0);
    chk_val({tag, "_drp_di"}, drp_di, 0);
  endtask

  // One reconfiguration request.
  //   d1/d2 : cycles from entering the read/write wait until drp_rdy is sampled (>LOCK_TIMEOUT = never)
  //   dl    : LOCKED is high from the dl-th edge after reset release (stale = high throughout)
  //   hold  : keep cfg_valid high (with junk fields) for the whole sequence
  //   rst_off : >0 pulls rst_n low at that many edges into the write wait
  task automatic run_txn(input logic [6:0] addr, input logic [15:0] data, input logic [15:0] mask,
                         input logic [15:0] rdata, input int d1, input int d2, input int dl,
                         input bit stale, input bit hold, input int rst_off);
    int c, a, r, w, h, e, fin, rst_fall, rk, last, j, rst_hi, n_done;
    bit ok, rd_hit, wr_hit, in_wait;
    logic [15:0] nw;
    c = cyc;
    a = (c + 1 > ready_from + 1) ? c + 1 : ready_from + 1;
    r = a + 2;
    w = -1; h = -1; e = -1; rk = -1; ok = 1'b0;
    nw = (rdata & mask) | (data & ~mask);
    if (d1 > LOCK_TIMEOUT) begin
      fin = r + LOCK_TIMEOUT;
    end else begin
      w = r + d1 + 1;
      if (rst_off > 0) rk = w + rst_off;
      if (d2 > LOCK_TIMEOUT) begin
        fin = w + LOCK_TIMEOUT;
      end else begin
        h = w + d2;
        e = h + RST_HOLD;
        j = stale ? LOCK_BLANK + 1 : ((dl > LOCK_BLANK + 1) ? dl : LOCK_BLANK + 1);
        if (j <= LOCK_TIMEOUT) begin
          fin = e + j;
          ok  = 1'b1;
        end else begin
          fin = e + LOCK_TIMEOUT;
        end
      end
    end
    rst_fall = (e >= 0) ? e : fin;
    last = (rk > 0) ? rk : fin;
    rst_hi = 0;
    n_done = 0;

    for (int k = c + 1; k <= last; k++) begin
      cfg_valid = hold ? 1'b1 : (k <= a);
      if (k <= a) begin
        cfg_addr = addr;
        cfg_data = data;
        cfg_mask = mask;
      end else begin
        cfg_addr = 7'($urandom);
        cfg_data = 16'($urandom);
        cfg_mask = 16'($urandom);
      end
      rd_hit  = (d1 <= LOCK_TIMEOUT) && (k == r + d1);
      wr_hit  = (w >= 0) && (d2 <= LOCK_TIMEOUT) && (k == w + d2);
      in_wait = (k > r && k <= r + ((d1 < LOCK_TIMEOUT) ? d1 : LOCK_TIMEOUT)) ||
                (w >= 0 && k > w && k <= w + ((d2 < LOCK_TIMEOUT) ? d2 : LOCK_TIMEOUT));
      drp_rdy = (rd_hit || wr_hit) ? 1'b1 : (in_wait ? 1'b0 : 1'($urandom_range(0, 1)));
      drp_do  = rd_hit ? rdata : 16'($urandom);
      if (stale)
        mmcm_locked = 1'b1;
      else if (e >= 0 && k > e)
        mmcm_locked = (k >= e + dl) || (k <= e + LOCK_BLANK && $urandom_range(0, 1) == 1);
      else
        mmcm_locked = 1'($urandom_range(0, 1));
      rst_n = (k != rk);
      tick();

      if (k == rk) begin
        chk_all_zero("mid_rst");
        ready_from = k + 1;
      end else begin
        chk_val("busy", busy, (k >= a && k < fin));
        chk_val("cfg_ready", cfg_ready, ((k >= ready_from && k < a) || k >= fin));
        chk_val("mmcm_rst", mmcm_rst, (k >= a && k < rst_fall));
        chk_val("drp_en", drp_en, (k == a + 1 || k == w));
        chk_val("drp_we", drp_we, (k == w));
        chk_val("done", done, (ok && k == fin));
        chk_val("err", err, (!ok && k == fin));
        if (k >= a + 1) chk_val("drp_addr", drp_addr, addr);
        if (w >= 0 && k >= w) chk_val("drp_di", drp_di, nw);
        if (mmcm_rst) rst_hi++;
        if (done) n_done++;
      end
    end
    rst_n = 1'b1;
    if (rk < 0) begin
      ready_from = fin;
      chk_val("done_count", n_done, ok);
      if (ok) chk_val("rst_hold_min", (rst_hi >= RST_HOLD + 4), 1);
    end
    if (!hold) cfg_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    cfg_valid = 1'b0;
    cfg_addr = '0;
    cfg_data = '0;
    cfg_mask = '0;
    drp_do = '0;
    drp_rdy = 1'b0;
    mmcm_locked = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    chk_all_zero("reset");
    rst_n = 1'b1;
    ready_from = cyc + 1;

    // Nominal example: expect drp_di = 0x1041.
    run_txn(7'h08, 16'h0041, 16'hF000, 16'h1234, 1, 1, 10, 1'b0, 1'b0, 0);

    // Random sequences, all completing.
    for (int i = 0; i < 12; i++)
      run_txn(7'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
              $urandom_range(1, 6), $urandom_range(1, 6), $urandom_range(1, 15),
              ($urandom_range(0, 4) == 0), 1'b0, 0);

    // Timeouts in each wait state.
    run_txn(7'h11, 16'hAAAA, 16'h00FF, 16'h5555, LOCK_TIMEOUT + 3, 1, 1, 1'b0, 1'b0, 0);
    run_txn(7'h12, 16'h1357, 16'h0F0F, 16'h2468, 2, LOCK_TIMEOUT + 1, 1, 1'b0, 1'b0, 0);
    run_txn(7'h13, 16'hBEEF, 16'hFF00, 16'hCAFE, 1, 2, 100000, 1'b0, 1'b0, 0);

    // Response on the final allowed cycle: success wins.
    run_txn(7'h14, 16'h0F0F, 16'h3C3C, 16'hFFFF, LOCK_TIMEOUT, LOCK_TIMEOUT, LOCK_TIMEOUT, 1'b0, 1'b0, 0);

    // Stale LOCKED held high throughout.
    run_txn(7'h15, 16'h8001, 16'h7FFE, 16'h0000, 1, 1, 0, 1'b1, 1'b0, 0);

    // Reset while waiting for the write response, then a normal request.
    run_txn(7'h16, 16'h4242, 16'h0000, 16'h9999, 2, LOCK_TIMEOUT + 10, 5, 1'b0, 1'b0, 3);
    run_txn(7'h17, 16'h0001, 16'hFFFE, 16'h8000, 1, 3, 7, 1'b0, 1'b0, 0);

    // cfg_valid held high across back-to-back requests.
    run_txn(7'h21, 16'h1111, 16'hF0F0, 16'h2222, 3, 2, 6, 1'b0, 1'b1, 0);
    run_txn(7'h22, 16'h3333, 16'h0FF0, 16'h4444, 1, 4, 9, 1'b0, 1'b1, 0);
    run_txn(7'h23, 16'h5555, 16'hFFFF, 16'h6666, 2, 1, 2, 1'b0, 1'b0, 0);

    tick();
    chk_val("idle_busy", busy, 0);
    chk_val("idle_ready", cfg_ready, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pll_reconfig_sequencer.md
PLL_RECONFIG_SEQUENCER -- requirements
Module: pll_reconfig_sequencer

Interface
REQ-001 SHALL have parameter RST_HOLD, default 8: minimum cycles mmcm_rst stays high after the DRP write completes.
REQ-002 SHALL have parameter LOCK_TIMEOUT, default 50000: maximum cycles to wait for drp_rdy or for lock.
REQ-003 SHALL have parameter LOCK_BLANK, default 4: cycles after mmcm_rst release during which mmcm_locked is ignored.
REQ-004 SHALL have port clk_125mhz, input, 1 bit: sole clock; all logic rising-edge.
REQ-005 SHALL have port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-006 SHALL have port cfg_valid, input, 1 bit: reconfiguration request.
REQ-007 SHALL have port cfg_ready, output, 1 bit: request accepted when cfg_valid and cfg_ready are both high.
REQ-008 SHALL have port cfg_addr, input, 7 bits: DRP register address.
REQ-009 SHALL have port cfg_data, input, 16 bits: new field bits.
REQ-010 SHALL have port cfg_mask, input, 16 bits: 1 = keep existing bit, 0 = take cfg_data bit.
REQ-011 SHALL have ports drp_en, drp_we (outputs, 1 bit), drp_addr (output, 7 bits), drp_di (output, 16 bits), drp_do (input, 16 bits) and drp_rdy (input, 1 bit), connecting to the MMCM/PLL DRP.
REQ-012 SHALL have port mmcm_rst, output, 1 bit: reset to the MMCM/PLL.
REQ-013 SHALL have port mmcm_locked, input, 1 bit: LOCKED from the MMCM/PLL.
REQ-014 SHALL have ports busy, done and err, outputs, 1 bit each: sequencer active; single-cycle success pulse; single-cycle timeout pulse.

Function
REQ-015 SHALL implement FSM states IDLE, ASSERT_RST, READ, WAIT_READ, WRITE, WAIT_WRITE, HOLD_RST and WAIT_LOCK.
REQ-016 SHALL drive cfg_ready=1 only in IDLE and busy=1 in every state except IDLE.
REQ-017 SHALL, on handshake in IDLE, latch cfg_addr, cfg_data and cfg_mask, and enter ASSERT_RST.
REQ-018 SHALL set mmcm_rst=1 from the entry to ASSERT_RST until the exit from HOLD_RST.
REQ-019 SHALL spend exactly 1 cycle in ASSERT_RST.
REQ-020 SHALL, in READ, pulse drp_en=1 and drp_we=0 for exactly 1 cycle with drp_addr equal to the latched address.
REQ-021 SHALL, in WAIT_READ, on drp_rdy register new = (drp_do AND mask) OR (data AND NOT mask).
REQ-022 SHALL, in WRITE, pulse drp_en=1 and drp_we=1 for exactly 1 cycle with drp_di=new.
REQ-023 SHALL leave WAIT_WRITE on drp_rdy, then stay in HOLD_RST for exactly RST_HOLD cycles.
REQ-024 SHALL, in WAIT_LOCK, ignore mmcm_locked for the first LOCK_BLANK cycles, then on mmcm_locked=1 pulse done for 1 cycle and return to IDLE.
REQ-025 SHALL count cycles in WAIT_READ, WAIT_WRITE and WAIT_LOCK (counter cleared on state entry); on reaching LOCK_TIMEOUT it SHALL pulse err for 1 cycle, set mmcm_rst=0 and go to IDLE.
REQ-026 SHALL ignore drp_rdy outside WAIT_READ/WAIT_WRITE, and cfg_valid outside IDLE.
REQ-027 SHALL hold drp_addr and drp_di stable from the strobe until drp_rdy; drp_en SHALL never be high in two consecutive cycles.
REQ-028 SHALL never assert done and err in the same cycle; if drp_rdy or lock coincides with timeout, success wins.

Reset
REQ-029 SHALL, while rst_n=0 at a clock edge, enter IDLE and drive mmcm_rst, drp_en, drp_we, done, err and busy to 0, drp_addr and drp_di to 0, and clear all counters.
REQ-030 SHALL, on reset mid-sequence, abandon the operation with no done/err pulse and mmcm_rst deasserted on the next edge.

Verification
REQ-031 Nominal: addr=0x08, data=0x0041, mask=0xF000, DRP returns 0x1234, lock 10 cycles after release -> drp_di=0x1041, mmcm_rst high ≥ RST_HOLD+4 cycles, one done pulse, busy low afterward.
REQ-032 Timing: accept at edge N -> mmcm_rst=1 at N+1, read drp_en at N+2, drp_rdy one cycle later -> write drp_en exactly 2 cycles after drp_rdy.
REQ-033 Lock timeout: mmcm_locked held 0 -> err pulse exactly LOCK_TIMEOUT cycles after WAIT_LOCK entry, no done, mmcm_rst=0, cfg_ready=1.
REQ-034 Stale lock: mmcm_locked held 1 throughout -> done not before LOCK_BLANK+1 cycles after release.
REQ-035 Reset mid-sequence: rst_n low during WAIT_WRITE -> next edge all outputs 0, no done/err; a new request is then accepted normally.
REQ-036 Back-pressure: cfg_valid held high while busy -> no second accept until the cycle after done.
